// File: rtl/icc_branch_unit.sv
// icc_branch_unit: SPARC {N,Z,V,C} register and Bicc resolution with delay-slot annul.
// Define ICC_FWD_EN to let a branch see flags_in written in the same cycle.
module icc_branch_unit #(
    parameter logic [3:0] ICC_RESET = 4'b0000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       stall,
    input  logic       icc_we,
    input  logic [3:0] flags_in,
    input  logic       br_valid,
    input  logic [3:0] cond,
    input  logic       a_bit,
    input  logic       slot_done,
    output logic [3:0] icc,
    output logic       cin,
    output logic       taken,
    output logic       annul_slot,
    output logic       dcti_err
);
    typedef enum logic {IDLE, SLOT} state_t;
    state_t     r_state, w_state_nx;
    logic [3:0] r_icc, w_flags;
    logic       r_taken, r_annul, w_taken_nx, w_annul_nx, w_dcti;
    logic       w_n, w_z, w_v, w_c, w_eval;
    logic [7:0] w_tbl;
`ifdef ICC_FWD_EN
    assign w_flags = icc_we ? flags_in : r_icc;
`else
    assign w_flags = r_icc;
`endif
    assign {w_n, w_z, w_v, w_c} = w_flags;
    // cond[3] inverts the base test selected by cond[2:0]
    assign w_tbl  = {w_v, w_n, w_c, w_c | w_z, w_n ^ w_v, w_z | (w_n ^ w_v), w_z, 1'b0};
    assign w_eval = cond[3] ^ w_tbl[cond[2:0]];
    always_comb begin
        w_state_nx = r_state;
        w_taken_nx = r_taken;
        w_annul_nx = r_annul;
        w_dcti     = 1'b0;
        if (!stall) begin
            if (r_state == IDLE && br_valid) begin
                w_state_nx = SLOT;
                w_taken_nx = w_eval;
                w_annul_nx = a_bit & (~w_eval | (cond == 4'b1000));
            end else if (r_state == SLOT) begin
                w_dcti = br_valid;
                if (slot_done) begin
                    w_state_nx = IDLE;
                    w_taken_nx = 1'b0;
                    w_annul_nx = 1'b0;
                end
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_icc   <= ICC_RESET;
            r_taken <= 1'b0;
            r_annul <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_taken <= w_taken_nx;
            r_annul <= w_annul_nx;
            if (icc_we && !stall) r_icc <= flags_in;
        end
    end
    assign icc        = r_icc;
    assign cin        = r_icc[0];
    assign taken      = r_taken;
    assign annul_slot = r_annul;
    assign dcti_err   = w_dcti;
endmodule

// File: tb/tb_icc_branch_unit.sv
// tb_icc_branch_unit: directed checks of condition codes, Bicc evaluation, annul, stall and reset.
module tb_icc_branch_unit;
    logic       clk = 1'b0, rst_n, stall, icc_we, br_valid, a_bit, slot_done;
    logic [3:0] flags_in, cond, icc;
    logic       cin, taken, annul_slot, dcti_err;
    int         tests = 0, fails = 0;
    always #5 clk = ~clk;
    icc_branch_unit dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .icc_we(icc_we), .flags_in(flags_in),
        .br_valid(br_valid), .cond(cond), .a_bit(a_bit), .slot_done(slot_done),
        .icc(icc), .cin(cin), .taken(taken), .annul_slot(annul_slot), .dcti_err(dcti_err)
    );
    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic br(input logic [3:0] c, input logic a);
        br_valid = 1'b1; cond = c; a_bit = a;
        tick();
        br_valid = 1'b0;
    endtask
    task automatic finish_slot();
        slot_done = 1'b1;
        tick();
        slot_done = 1'b0;
    endtask
    initial begin
        rst_n = 1'b0; stall = 1'b0; icc_we = 1'b0; flags_in = 4'h0;
        br_valid = 1'b0; cond = 4'h0; a_bit = 1'b0; slot_done = 1'b0;
        #3;
        chk("rst_icc", icc, 4'b0000);
        chk("rst_cin", cin, 0);
        chk("rst_taken", taken, 0);
        chk("rst_annul", annul_slot, 0);
        chk("rst_dcti", dcti_err, 0);
        #9 rst_n = 1'b1;
        icc_we = 1'b1; flags_in = 4'b0100;
        tick();
        icc_we = 1'b0;
        chk("ld_icc", icc, 4'b0100);
        chk("ld_cin", cin, 0);
        br(4'b0001, 1'b0);
        chk("be_taken", taken, 1);
        chk("be_annul", annul_slot, 0);
        finish_slot();
        chk("be_done_taken", taken, 0);
        icc_we = 1'b1; flags_in = 4'b1000;
        tick();
        icc_we = 1'b0;
        chk("ld2_icc", icc, 4'b1000);
        br(4'b0011, 1'b1);
        chk("bl_taken", taken, 1);
        chk("bl_annul", annul_slot, 0);
        finish_slot();
        br(4'b1011, 1'b1);
        chk("bge_taken", taken, 0);
        chk("bge_annul", annul_slot, 1);
        finish_slot();
        chk("bge_done_annul", annul_slot, 0);
        br(4'b0000, 1'b1);
        chk("bn_taken", taken, 0);
        chk("bn_annul", annul_slot, 1);
        finish_slot();
        br(4'b1000, 1'b1);
        chk("ba_taken", taken, 1);
        chk("ba_annul", annul_slot, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ba_hold_taken", taken, 1);
            chk("ba_hold_annul", annul_slot, 1);
        end
        finish_slot();
        chk("ba_done_taken", taken, 0);
        chk("ba_done_annul", annul_slot, 0);
        br(4'b1001, 1'b0);
        chk("bne_taken", taken, 1);
        chk("bne_annul", annul_slot, 0);
        br_valid = 1'b1; cond = 4'b0000;
        #1;
        chk("dcti_high", dcti_err, 1);
        tick();
        br_valid = 1'b0;
        #1;
        chk("dcti_low", dcti_err, 0);
        chk("dcti_taken", taken, 1);
        stall = 1'b1; slot_done = 1'b1; br_valid = 1'b1; icc_we = 1'b1; flags_in = 4'b1111;
        #1;
        chk("stall_dcti", dcti_err, 0);
        tick();
        chk("stall_taken", taken, 1);
        chk("stall_annul", annul_slot, 0);
        chk("stall_icc", icc, 4'b1000);
        stall = 1'b0; slot_done = 1'b0; icc_we = 1'b0;
        #1;
        chk("stall_still_slot", dcti_err, 1);
        slot_done = 1'b1; cond = 4'b1000;
        #1;
        chk("both_dcti", dcti_err, 1);
        tick();
        slot_done = 1'b0; br_valid = 1'b0;
        chk("both_taken", taken, 0);
        chk("both_dcti_off", dcti_err, 0);
        icc_we = 1'b1; flags_in = 4'b0000;
        tick();
        chk("clr_icc", icc, 4'b0000);
        flags_in = 4'b0001;
        br(4'b0101, 1'b0);
        icc_we = 1'b0;
`ifdef ICC_FWD_EN
        chk("bcs_fwd_taken", taken, 1);
`else
        chk("bcs_fwd_taken", taken, 0);
`endif
        chk("bcs_icc", icc, 4'b0001);
        chk("bcs_cin", cin, 1);
        finish_slot();
        br(4'b1000, 1'b1);
        chk("pre_rst_taken", taken, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_taken", taken, 0);
        chk("arst_annul", annul_slot, 0);
        chk("arst_icc", icc, 4'b0000);
        chk("arst_cin", cin, 0);
        #1 rst_n = 1'b1;
        br(4'b1000, 1'b0);
        chk("post_rst_taken", taken, 1);
        chk("post_rst_annul", annul_slot, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
